// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD display blocks: active-low seven-segment
// patterns (bit 7 = DP, bits 6:0 = g..a) and an elaboration-time decimal-to-BCD converter.
package bcd_disp_pkg;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Converts a decimal integer into up to eight packed BCD digits, digit 0 in [3:0].
   function automatic logic [31:0] dec_to_bcd(input int unsigned value);
      logic [31:0] res;
      int unsigned v;
      res = '0;
      v   = value;
      for (int i = 0; i < 8; i++) begin
         res[4*i +: 4] = 4'(v % 10);
         v             = v / 10;
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern. Codes above 9 blank the digit.
module seg7_decode
   import bcd_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [7:0] seg
);

   // Digit lookup; DP stays off for every code
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/bcd_tick_counter_7seg.sv
// Decimal tick counter with direct-drive seven-segment outputs.
// A prescaler divides INCLK down to the tick rate; each tick steps a DIGITS-wide BCD counter
// that wraps at COUNT_MAX and pulses CARRY. Segment outputs are registered one cycle after BCD.
// Optional feature: define BCDCNT_DOWN_EN to honour DIR (down-count with borrow, wrap to
// COUNT_MAX). Without it the counter is up-only and DIR is ignored.
module bcd_tick_counter_7seg
   import bcd_disp_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 10000000,
   parameter int unsigned TICK_HZ   = 5,
   parameter int unsigned DIGITS    = 2,
   parameter int unsigned COUNT_MAX = 99
) (
   input  logic                  INCLK,
   input  logic                  RESET,
   input  logic                  EN,
   input  logic                  CLR,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
   input  logic                  DIR,
   output logic [4*DIGITS-1:0]   BCD,
   output logic                  TICK,
   output logic                  CARRY,
   output logic [8*DIGITS-1:0]   SEG
);

   localparam int unsigned          DIV         = CLK_HZ / TICK_HZ;
   localparam int unsigned          PC_W        = $clog2(DIV);
   localparam logic [PC_W-1:0]      PC_LAST     = PC_W'(DIV - 1);
   localparam logic [31:0]          MAX_BCD_ALL = dec_to_bcd(COUNT_MAX);
   localparam logic [4*DIGITS-1:0]  MAX_BCD     = MAX_BCD_ALL[4*DIGITS-1:0];

   logic [PC_W-1:0]     pc_q, pc_d;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;
   logic                tick_q, tick_d;
   logic                carry_q, carry_d;
   logic [8*DIGITS-1:0] seg_q, seg_dec;

   logic [4*DIGITS-1:0] bcd_inc;
   logic                inc_carry;
   logic [4*DIGITS-1:0] load_clamped;
   logic [4*DIGITS-1:0] bcd_next;
   logic                wrap;

   // Ripple +1 across digits; a digit at 9 rolls to 0 and passes the carry on
   always_comb begin
      bcd_inc   = bcd_q;
      inc_carry = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (inc_carry) begin
            if (bcd_q[4*i +: 4] >= 4'd9) begin
               bcd_inc[4*i +: 4] = 4'd0;
            end else begin
               bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
               inc_carry         = 1'b0;
            end
         end
      end
   end

`ifdef BCDCNT_DOWN_EN
   logic [4*DIGITS-1:0] bcd_dec;
   logic                dec_borrow;

   // Ripple -1 across digits; a digit at 0 rolls to 9 and passes the borrow on
   always_comb begin
      bcd_dec    = bcd_q;
      dec_borrow = 1'b1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (dec_borrow) begin
            if (bcd_q[4*i +: 4] == 4'd0) begin
               bcd_dec[4*i +: 4] = 4'd9;
            end else begin
               bcd_dec[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
               dec_borrow        = 1'b0;
            end
         end
      end
   end

   // Select the step result by direction, including the wrap endpoints
   always_comb begin
      if (DIR) begin
         wrap     = (bcd_q == '0);
         bcd_next = wrap ? MAX_BCD : bcd_dec;
      end else begin
         wrap     = (bcd_q >= MAX_BCD);
         bcd_next = wrap ? '0 : bcd_inc;
      end
   end
`else
   logic unused_dir;
   assign unused_dir = DIR;

   // Up-only step; values at or above the wrap point return to zero
   always_comb begin
      wrap     = (bcd_q >= MAX_BCD);
      bcd_next = wrap ? '0 : bcd_inc;
   end
`endif

   // Loaded digits above 9 saturate to 9 so the counter never holds an invalid code
   always_comb begin
      load_clamped = LOAD_VAL;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (LOAD_VAL[4*i +: 4] > 4'd9) begin
            load_clamped[4*i +: 4] = 4'd9;
         end
      end
   end

   // Next state with CLR over LOAD over tick; CLR/LOAD restart the prescaler
   always_comb begin
      pc_d    = pc_q;
      bcd_d   = bcd_q;
      tick_d  = 1'b0;
      carry_d = 1'b0;
      if (CLR) begin
         pc_d  = '0;
         bcd_d = '0;
      end else if (LOAD) begin
         pc_d  = '0;
         bcd_d = load_clamped;
      end else if (EN) begin
         if (pc_q == PC_LAST) begin
            pc_d    = '0;
            bcd_d   = bcd_next;
            tick_d  = 1'b1;
            carry_d = wrap;
         end else begin
            pc_d = pc_q + PC_W'(1);
         end
      end
   end

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
      seg7_decode u_dec (
         .bcd (bcd_q[4*g +: 4]),
         .seg (seg_dec[8*g +: 8])
      );
   end

   // State and output registers; SEG samples the current count so it trails BCD by one cycle
   always_ff @(posedge INCLK or negedge RESET) begin
      if (!RESET) begin
         pc_q    <= '0;
         bcd_q   <= '0;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
         seg_q   <= {DIGITS{SEG_0}};
      end else begin
         pc_q    <= pc_d;
         bcd_q   <= bcd_d;
         tick_q  <= tick_d;
         carry_q <= carry_d;
         seg_q   <= seg_dec;
      end
   end

   assign BCD   = bcd_q;
   assign TICK  = tick_q;
   assign CARRY = carry_q;
   assign SEG   = seg_q;

endmodule

// File: tb/tb_bcd_tick_counter_7seg.sv
// Scoreboard bench: an integer-level reference model predicts each tick and queues it; a
// monitor pops on every TICK and also checks the per-cycle count and segment outputs.
// Two instances run in parallel: COUNT_MAX=99 and COUNT_MAX=59.
module tb_bcd_tick_counter_7seg;

   localparam int DIV = 10;

   typedef struct {
      int cyc;
      int val;
      bit carry;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic        dir = 1'b0;
   logic [7:0]  load_val = 8'h00;

   logic [7:0]  bcd0, bcd1;
   logic        tick0, tick1, carry0, carry1;
   logic [15:0] seg0, seg1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
   int         maxv [2]    = '{99, 59};

   int          m_cnt [2];
   logic [15:0] m_seg [2];
   int          m_pc;
   int          m_cyc   = 0;
   int          mon_cyc = 0;
   exp_t        q0 [$];
   exp_t        q1 [$];

   always #5 clk = ~clk;

   bcd_tick_counter_7seg #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .COUNT_MAX(99)) dut (
      .INCLK(clk), .RESET(rst_n), .EN(en), .CLR(clr), .LOAD(load), .LOAD_VAL(load_val),
      .DIR(dir), .BCD(bcd0), .TICK(tick0), .CARRY(carry0), .SEG(seg0)
   );

   bcd_tick_counter_7seg #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .COUNT_MAX(59)) dut59 (
      .INCLK(clk), .RESET(rst_n), .EN(en), .CLR(clr), .LOAD(load), .LOAD_VAL(load_val),
      .DIR(dir), .BCD(bcd1), .TICK(tick1), .CARRY(carry1), .SEG(seg1)
   );

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r[3:0] = 4'(v % 10);
      r[7:4] = 4'((v / 10) % 10);
      return r;
   endfunction

   function automatic logic [15:0] seg_of(input int v);
      return {segtab[(v / 10) % 10], segtab[v % 10]};
   endfunction

   function automatic int clamp_dec(input logic [7:0] x);
      int hi, lo;
      hi = (x[7:4] > 4'd9) ? 9 : int'(x[7:4]);
      lo = (x[3:0] > 4'd9) ? 9 : int'(x[3:0]);
      return hi * 10 + lo;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, mon_cyc);
      end
   endtask

   task automatic model_reset();
      m_pc = 0;
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_seg[k] = seg_of(0);
      end
   endtask

   // One clock edge of the reference behaviour, using the inputs held across the edge
   task automatic model_step();
      exp_t e;
      bit   down;
      m_cyc++;
      down = 1'b0;
`ifdef BCDCNT_DOWN_EN
      down = dir;
`endif
      for (int k = 0; k < 2; k++) m_seg[k] = seg_of(m_cnt[k]);
      if (!rst_n) begin
         model_reset();
      end else if (clr) begin
         m_pc = 0;
         for (int k = 0; k < 2; k++) m_cnt[k] = 0;
      end else if (load) begin
         m_pc = 0;
         for (int k = 0; k < 2; k++) m_cnt[k] = clamp_dec(load_val);
      end else if (en) begin
         if (m_pc == DIV - 1) begin
            m_pc = 0;
            for (int k = 0; k < 2; k++) begin
               if (down) begin
                  e.carry = (m_cnt[k] == 0);
                  e.val   = e.carry ? maxv[k] : m_cnt[k] - 1;
               end else begin
                  e.carry = (m_cnt[k] >= maxv[k]);
                  e.val   = e.carry ? 0 : m_cnt[k] + 1;
               end
               e.cyc    = m_cyc;
               m_cnt[k] = e.val;
               if (k == 0) q0.push_back(e);
               else        q1.push_back(e);
            end
         end else begin
            m_pc++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   function automatic int q_size(input int k);
      return (k == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t q_pop(input int k);
      return (k == 0) ? q0.pop_front() : q1.pop_front();
   endfunction

   task automatic mon_dut(input int k, input logic [7:0] b, input logic t, input logic c,
                          input logic [15:0] s);
      exp_t e;
      check($sformatf("bcd%0d", k), b, to_bcd(m_cnt[k]));
      check($sformatf("seg%0d", k), s, m_seg[k]);
      // Anything still queued for an earlier cycle is a tick the DUT never produced
      while (q_size(k) > 0 && ((k == 0) ? q0[0].cyc : q1[0].cyc) < mon_cyc) begin
         e = q_pop(k);
         check($sformatf("missed_tick%0d_cycle", k), mon_cyc, e.cyc);
      end
      if (t) begin
         if (q_size(k) == 0) begin
            check($sformatf("unexpected_tick%0d", k), t, 1'b0);
         end else begin
            e = q_pop(k);
            check($sformatf("tick%0d_cycle", k), mon_cyc, e.cyc);
            check($sformatf("tick%0d_bcd", k), b, to_bcd(e.val));
            check($sformatf("tick%0d_carry", k), c, e.carry);
         end
      end else begin
         check($sformatf("carry%0d_idle", k), c, 1'b0);
      end
   endtask

   // Monitor: sample on the falling edge, away from the active edge
   initial begin
      forever begin
         @(posedge clk);
         mon_cyc++;
         @(negedge clk);
         mon_dut(0, bcd0, tick0, carry0, seg0);
         mon_dut(1, bcd1, tick1, carry1, seg1);
      end
   end

   initial begin
      int guard;
      model_reset();
      repeat (3) step();
      check("rst_bcd", bcd0, 8'h00);
      check("rst_tick", tick0, 1'b0);
      check("rst_carry", carry0, 1'b0);
      check("rst_seg", seg0, 16'hC0C0);

      // Release reset and count: first tick after DIV edges
      rst_n = 1'b1;
      en    = 1'b1;
      repeat (10) step();
      check("first_tick_bcd", bcd0, 8'h01);
      check("first_tick_pulse", tick0, 1'b1);
      step();
      check("first_tick_seg", seg0, 16'hC0F9);

      // Run to 99, then wrap to 00 with a one-cycle carry
      repeat (979) step();
      check("at_99", bcd0, 8'h99);
      repeat (10) step();
      check("wrap_bcd", bcd0, 8'h00);
      check("wrap_carry", carry0, 1'b1);
      step();
      check("wrap_carry_clear", carry0, 1'b0);

      // Load 58 on the COUNT_MAX=59 instance: two ticks later it wraps
      load = 1'b1; load_val = 8'h58;
      step();
      load = 1'b0;
      check("load58", bcd1, 8'h58);
      check("load_no_tick", tick1, 1'b0);
      repeat (20) step();
      check("max59_wrap", bcd1, 8'h00);
      check("max59_carry", carry1, 1'b1);
      check("max99_at_60", bcd0, 8'h60);

      // Out-of-range digit saturates on load
      load = 1'b1; load_val = 8'hA3;
      step();
      load = 1'b0;
      check("load_clamp", bcd0, 8'h93);

      // EN low for 7 cycles mid-interval delays the tick by 7
      repeat (4) step();
      en = 1'b0;
      repeat (7) step();
      en = 1'b1;
      repeat (5) step();
      check("en_hold_no_tick", bcd0, 8'h93);
      step();
      check("en_hold_tick", tick0, 1'b1);
      check("en_hold_bcd", bcd0, 8'h94);

      // CLR and LOAD together on the tick edge: count clears, tick suppressed
      guard = 0;
      while (m_pc != DIV - 1 && guard < 20) begin
         step();
         guard++;
      end
      check("pending_tick_reached", m_pc, DIV - 1);
      clr = 1'b1; load = 1'b1; load_val = 8'h42;
      step();
      clr = 1'b0; load = 1'b0;
      check("clr_load_bcd", bcd0, 8'h00);
      check("clr_load_no_tick", tick0, 1'b0);
      repeat (9) step();
      check("clr_load_gap", tick0, 1'b0);
      step();
      check("clr_load_next_tick", tick0, 1'b1);
      check("clr_load_next_bcd", bcd0, 8'h01);

`ifdef BCDCNT_DOWN_EN
      // Down-count: 00 wraps to COUNT_MAX, 10 borrows to 09
      clr = 1'b1;
      step();
      clr = 1'b0;
      dir = 1'b1;
      repeat (10) step();
      check("down_wrap_bcd", bcd0, 8'h99);
      check("down_wrap_carry", carry0, 1'b1);
      load = 1'b1; load_val = 8'h10;
      step();
      load = 1'b0;
      repeat (10) step();
      check("down_borrow", bcd0, 8'h09);
      dir = 1'b0;
`endif

      // Randomised control traffic; the monitor checks every cycle against the model
      repeat (3000) begin
         en       = ($urandom_range(0, 9) != 0);
         clr      = ($urandom_range(0, 199) == 0);
         load     = ($urandom_range(0, 99) == 0);
         load_val = 8'($urandom);
         dir      = 1'($urandom_range(0, 1));
         step();
      end
      en = 1'b1; clr = 1'b0; load = 1'b0; dir = 1'b0;

      // Asynchronous reset mid-count, asserted between edges
      repeat (13) step();
      #5;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_rst_bcd", bcd0, 8'h00);
      check("async_rst_seg", seg0, 16'hC0C0);
      check("async_rst_tick", tick0, 1'b0);
      step();
      rst_n = 1'b1;
      repeat (10) step();
      check("post_rst_tick", tick0, 1'b1);
      check("post_rst_bcd", bcd0, 8'h01);

      repeat (2) step();
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
